counter_updown_mod: RTL and testbench

// - Parametrised up/down counter with a programmable step, a runtime modulus (limit) and a parallel load.
// - Wrap or saturate mode; flags for zero, limit and overflow/underflow.
// - Used as a general-purpose sequencer/divider counter in lab designs; successor of the fixed 4-bit +1/+2 up/down counter.

---
 rtl/counter_updown_mod_if.sv | 32 +++
 rtl/counter_updown_mod.sv | 106 ++++++++++
 tb/tb_counter_updown_mod.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/counter_updown_mod_if.sv
// Bus bundle for counter_updown_mod: control/data inputs driven by the
// user of the counter and the registered count plus status flags it returns.
interface counter_updown_mod_if #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 2
);

  logic              en;
  logic              down;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic [WIDTH-1:0]  limit;
  logic [WIDTH-1:0]  out;
  logic              wrap;
  logic              step_err;
  logic              at_zero;
  logic              at_limit;

  // Side that controls the counter and observes its value
  modport master (
    output en, down, step, load, load_val, limit,
    input  out, wrap, step_err, at_zero, at_limit
  );

  // The counter itself
  modport slave (
    input  en, down, step, load, load_val, limit,
    output out, wrap, step_err, at_zero, at_limit
  );

endinterface

// File: rtl/counter_updown_mod.sv
// Up/down counter with programmable step, runtime modulus (limit + 1) and
// parallel load. SATURATE selects between modulo wrap and clamping at the
// ends of the range. wrap and step_err are registered one-cycle pulses;
// at_zero and at_limit are decoded combinationally from the count.
module counter_updown_mod #(
  parameter int WIDTH    = 4,
  parameter int STEP_W   = 2,
  parameter bit SATURATE = 1'b0
) (
  input logic                clk,
  input logic                rst,
  counter_updown_mod_if.slave bus
);

  localparam int EW = WIDTH + 1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             err_q;
  logic             err_d;

  // One extra bit so that limit + 1 and count + step never overflow
  logic [EW-1:0]    count_x;
  logic [EW-1:0]    limit_x;
  logic [EW-1:0]    mod_x;
  logic [EW-1:0]    step_x;
  logic [EW-1:0]    sum_x;
  logic [WIDTH-1:0] step_n;
  logic [WIDTH-1:0] up_wrapped;
  logic [WIDTH-1:0] down_plain;
  logic [WIDTH-1:0] down_wrapped;
  logic [WIDTH-1:0] load_clamped;

  assign count_x = EW'(count_q);
  assign limit_x = EW'(bus.limit);
  assign mod_x   = limit_x + EW'(1);
  assign step_x  = EW'(bus.step);
  assign sum_x   = count_x + step_x;
  assign step_n  = WIDTH'(bus.step);

  // Wrapped results always land inside 0..limit, so they are exact when
  // evaluated modulo 2**WIDTH
  assign up_wrapped   = count_q + step_n - bus.limit - WIDTH'(1);
  assign down_plain   = count_q - step_n;
  assign down_wrapped = count_q + bus.limit + WIDTH'(1) - step_n;
  assign load_clamped = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;

  // Next count and pulse flags: load first, then enabled counting, else hold
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      count_d = load_clamped;
    end else if (bus.en) begin
      if (step_x > mod_x) begin
        err_d = 1'b1;
      end else if (bus.step == '0) begin
        count_d = count_q;
      end else if (count_x > limit_x) begin
        wrap_d = 1'b1;
        if (bus.down || SATURATE) begin
          count_d = bus.limit;
        end else begin
          count_d = '0;
        end
      end else if (!bus.down) begin
        if (sum_x <= limit_x) begin
          count_d = count_q + step_n;
        end else begin
          wrap_d  = 1'b1;
          count_d = SATURATE ? bus.limit : up_wrapped;
        end
      end else begin
        if (step_x <= count_x) begin
          count_d = down_plain;
        end else begin
          wrap_d  = 1'b1;
          count_d = SATURATE ? '0 : down_wrapped;
        end
      end
    end
  end

  // Count and pulse registers, cleared asynchronously by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.out      = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.step_err = err_q;
  assign bus.at_zero  = (count_q == '0);
  assign bus.at_limit = (count_q == bus.limit);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: a wrapping and a saturating
// instance share the same stimulus; each step names the instance it checks
// and queues the expected count/flags, which are popped after the edge.
module tb_counter_updown_mod;

  localparam int WIDTH  = 4;
  localparam int STEP_W = 3;

  typedef struct {
    string            tag;
    int               sel;
    logic [WIDTH-1:0] out;
    logic             wrap;
    logic             err;
    logic [WIDTH-1:0] limit;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  counter_updown_mod_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus0 ();
  counter_updown_mod_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus1 ();

  counter_updown_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  counter_updown_mod #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SATURATE(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic l, input logic [WIDTH-1:0] lv, input logic e,
                       input logic d, input logic [STEP_W-1:0] s, input logic [WIDTH-1:0] lim);
    bus0.load = l; bus0.load_val = lv; bus0.en = e; bus0.down = d; bus0.step = s; bus0.limit = lim;
    bus1.load = l; bus1.load_val = lv; bus1.en = e; bus1.down = d; bus1.step = s; bus1.limit = lim;
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [WIDTH-1:0] o;
    logic w, er, az, al;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e  = sb.pop_front();
    o  = (e.sel == 1) ? bus1.out      : bus0.out;
    w  = (e.sel == 1) ? bus1.wrap     : bus0.wrap;
    er = (e.sel == 1) ? bus1.step_err : bus0.step_err;
    az = (e.sel == 1) ? bus1.at_zero  : bus0.at_zero;
    al = (e.sel == 1) ? bus1.at_limit : bus0.at_limit;
    cmp({e.tag, ".out"},      o,            e.out);
    cmp({e.tag, ".wrap"},     WIDTH'(w),    WIDTH'(e.wrap));
    cmp({e.tag, ".step_err"}, WIDTH'(er),   WIDTH'(e.err));
    cmp({e.tag, ".at_zero"},  WIDTH'(az),   WIDTH'(e.out == '0));
    cmp({e.tag, ".at_limit"}, WIDTH'(al),   WIDTH'(e.out == e.limit));
  endtask

  task automatic applyStimulus(input string tag, input int sel,
                               input logic l, input logic [WIDTH-1:0] lv, input logic e,
                               input logic d, input logic [STEP_W-1:0] s, input logic [WIDTH-1:0] lim,
                               input logic [WIDTH-1:0] xo, input logic xw, input logic xe);
    exp_t x;
    @(negedge clk);
    drive(l, lv, e, d, s, lim);
    x.tag = tag; x.sel = sel; x.out = xo; x.wrap = xw; x.err = xe; x.limit = lim;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'd15);
    #1;
    cmp("reset0.out", bus0.out, 4'd0);
    cmp("reset0.wrap", WIDTH'(bus0.wrap), 4'd0);
    cmp("reset0.step_err", WIDTH'(bus0.step_err), 4'd0);
    cmp("reset1.out", bus1.out, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full-range wrap, limit 15, step 1
    applyStimulus("full_load", 0, 1, 4'd0, 0, 0, 3'd0, 4'd15, 4'd0, 0, 0);
    for (int i = 0; i < 16; i++)
      applyStimulus($sformatf("full_up%0d", i), 0, 0, 4'd0, 1, 0, 3'd1, 4'd15,
                    WIDTH'((i + 1) % 16), (i == 15), 0);

    // Modulus 10, up by 2 then down by 3
    applyStimulus("m10_load0", 0, 1, 4'd0, 0, 0, 3'd0, 4'd9, 4'd0, 0, 0);
    applyStimulus("m10_up_a", 0, 0, 4'd0, 1, 0, 3'd2, 4'd9, 4'd2, 0, 0);
    applyStimulus("m10_up_b", 0, 0, 4'd0, 1, 0, 3'd2, 4'd9, 4'd4, 0, 0);
    applyStimulus("m10_up_c", 0, 0, 4'd0, 1, 0, 3'd2, 4'd9, 4'd6, 0, 0);
    applyStimulus("m10_up_d", 0, 0, 4'd0, 1, 0, 3'd2, 4'd9, 4'd8, 0, 0);
    applyStimulus("m10_up_wrap", 0, 0, 4'd0, 1, 0, 3'd2, 4'd9, 4'd0, 1, 0);
    applyStimulus("m10_up_e", 0, 0, 4'd0, 1, 0, 3'd2, 4'd9, 4'd2, 0, 0);
    applyStimulus("m10_load1", 0, 1, 4'd1, 0, 0, 3'd0, 4'd9, 4'd1, 0, 0);
    applyStimulus("m10_dn_wrap", 0, 0, 4'd0, 1, 1, 3'd3, 4'd9, 4'd8, 1, 0);
    applyStimulus("m10_dn_a", 0, 0, 4'd0, 1, 1, 3'd3, 4'd9, 4'd5, 0, 0);
    applyStimulus("m10_dn_b", 0, 0, 4'd0, 1, 1, 3'd3, 4'd9, 4'd2, 0, 0);
    applyStimulus("m10_dn_wrap2", 0, 0, 4'd0, 1, 1, 3'd3, 4'd9, 4'd9, 1, 0);

    // Load wins over enable and is clamped to limit
    applyStimulus("load_clamp", 0, 1, 4'd14, 1, 0, 3'd1, 4'd9, 4'd9, 0, 0);
    applyStimulus("load_then_up", 0, 0, 4'd0, 1, 0, 3'd1, 4'd9, 4'd0, 1, 0);

    // Step larger than modulus, hold, zero step
    applyStimulus("err_load", 0, 1, 4'd2, 0, 0, 3'd0, 4'd4, 4'd2, 0, 0);
    applyStimulus("err_pulse", 0, 0, 4'd0, 1, 0, 3'd6, 4'd4, 4'd2, 0, 1);
    applyStimulus("err_clear", 0, 0, 4'd0, 0, 0, 3'd6, 4'd4, 4'd2, 0, 0);
    applyStimulus("step_zero", 0, 0, 4'd0, 1, 0, 3'd0, 4'd4, 4'd2, 0, 0);
    applyStimulus("step_max_ok", 0, 0, 4'd0, 1, 1, 3'd5, 4'd4, 4'd2, 1, 0);

    // Count left outside a lowered limit
    applyStimulus("oor_load_a", 0, 1, 4'd12, 0, 0, 3'd0, 4'd15, 4'd12, 0, 0);
    applyStimulus("oor_up_wrap", 0, 0, 4'd0, 1, 0, 3'd1, 4'd5, 4'd0, 1, 0);
    applyStimulus("oor_load_b", 0, 1, 4'd12, 0, 0, 3'd0, 4'd15, 4'd12, 0, 0);
    applyStimulus("oor_dn_wrap", 0, 0, 4'd0, 1, 1, 3'd1, 4'd5, 4'd5, 1, 0);
    applyStimulus("oor_load_c", 1, 1, 4'd12, 0, 0, 3'd0, 4'd15, 4'd12, 0, 0);
    applyStimulus("oor_up_sat", 1, 0, 4'd0, 1, 0, 3'd1, 4'd5, 4'd5, 1, 0);

    // Limit zero pins the count at 0
    applyStimulus("lim0_load", 0, 1, 4'd3, 0, 0, 3'd0, 4'd0, 4'd0, 0, 0);
    applyStimulus("lim0_up", 0, 0, 4'd0, 1, 0, 3'd1, 4'd0, 4'd0, 1, 0);
    applyStimulus("lim0_dn", 0, 0, 4'd0, 1, 1, 3'd1, 4'd0, 4'd0, 1, 0);
    applyStimulus("lim0_err", 0, 0, 4'd0, 1, 0, 3'd2, 4'd0, 4'd0, 0, 1);

    // Saturating instance, limit 12
    applyStimulus("sat_load", 1, 1, 4'd10, 0, 0, 3'd0, 4'd12, 4'd10, 0, 0);
    applyStimulus("sat_up_clamp", 1, 0, 4'd0, 1, 0, 3'd3, 4'd12, 4'd12, 1, 0);
    applyStimulus("sat_up_hold", 1, 0, 4'd0, 1, 0, 3'd3, 4'd12, 4'd12, 1, 0);
    applyStimulus("sat_load2", 1, 1, 4'd2, 0, 0, 3'd0, 4'd12, 4'd2, 0, 0);
    applyStimulus("sat_dn_clamp", 1, 0, 4'd0, 1, 1, 3'd3, 4'd12, 4'd0, 1, 0);
    applyStimulus("sat_up_plain", 1, 0, 4'd0, 1, 0, 3'd3, 4'd12, 4'd3, 0, 0);

    // Asynchronous reset in the middle of a count
    applyStimulus("rst_load", 0, 1, 4'd5, 0, 0, 3'd0, 4'd15, 4'd5, 0, 0);
    applyStimulus("rst_up_a", 0, 0, 4'd0, 1, 0, 3'd1, 4'd15, 4'd6, 0, 0);
    applyStimulus("rst_up_b", 0, 0, 4'd0, 1, 0, 3'd1, 4'd15, 4'd7, 0, 0);
    #2;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, '0, 4'd15);
    #1;
    cmp("rst_async.out", bus0.out, 4'd0);
    @(posedge clk);
    #1;
    cmp("rst_held.out", bus0.out, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("rst_resume", 0, 0, 4'd0, 1, 0, 3'd1, 4'd15, 4'd1, 0, 0);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
